// File: rtl/quad_gate_bist_ctrl_if.sv
// Host/device bundle for the quad-gate BIST sequencer: run control, status and gate A/B/Y pins.
// master = test host plus gate package; slave = the sequencer.
interface quad_gate_bist_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 abort;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_cnt;
  logic [2*WIDTH-1:0]   fail_vec;
  logic                 fail_valid;

  modport master (
    output start, abort, op, y,
    input  a, b, busy, done, pass, err_cnt, fail_vec, fail_valid
  );

  modport slave (
    input  start, abort, op, y,
    output a, b, busy, done, pass, err_cnt, fail_vec, fail_valid
  );
endinterface

// File: rtl/quad_gate_bist_ctrl.sv
// Exhaustive BIST sequencer for a quad 2-input gate: SETTLE+1 cycles per vector, DONE 256*(SETTLE+1)+1
// cycles after START; no backpressure, START ignored while a run is in flight, ABORT ends a run early.
module quad_gate_bist_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  quad_gate_bist_ctrl_if.slave  io_bus
);

  localparam int VW  = 2 * WIDTH;
  localparam int CW  = VW + 1;
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPLY  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [VW-1:0]    r_vec;
  logic [STW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_pass;
  logic [CW-1:0]    r_err_cnt;
  logic [VW-1:0]    r_fail_vec;
  logic             r_fail_valid;

  logic [WIDTH-1:0] w_exp;
  logic             w_op_legal;
  logic             w_cmp;
  logic             w_mismatch;

  always_comb begin
    w_exp = '0;
    case (r_op)
      3'b000:  w_exp = r_a | r_b;
      3'b001:  w_exp = r_a & r_b;
      3'b010:  w_exp = ~(r_a & r_b);
      3'b011:  w_exp = ~(r_a | r_b);
      3'b100:  w_exp = r_a ^ r_b;
      default: w_exp = '0;
    endcase
  end

  assign w_op_legal = (io_bus.op <= 3'b100);
  // Y is only trusted on the last settle cycle, and an abort in that cycle discards the compare.
  assign w_cmp      = (r_state == S_SETTLE) && (r_cnt == '0) && !io_bus.abort;
  assign w_mismatch = w_cmp && (io_bus.y != w_exp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_op         <= 3'b000;
      r_vec        <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_op         <= io_bus.op;
            r_vec        <= '0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_state      <= w_op_legal ? S_APPLY : S_FINISH;
          end
        end
        S_APPLY: begin
          if (io_bus.abort) begin
            r_a     <= '0;
            r_b     <= '0;
            r_pass  <= 1'b0;
            r_state <= S_FINISH;
          end else begin
            r_a     <= r_vec[VW-1:WIDTH];
            r_b     <= r_vec[WIDTH-1:0];
            r_cnt   <= STW'(SETTLE - 1);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (io_bus.abort) begin
            r_a     <= '0;
            r_b     <= '0;
            r_pass  <= 1'b0;
            r_state <= S_FINISH;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (w_mismatch) begin
              if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
              if (!r_fail_valid) begin
                r_fail_vec   <= {r_a, r_b};
                r_fail_valid <= 1'b1;
              end
            end
            if (&r_vec) begin
              r_a     <= '0;
              r_b     <= '0;
              r_pass  <= (r_err_cnt == '0) && !w_mismatch;
              r_state <= S_FINISH;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_state <= S_APPLY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.a          = r_a;
  assign io_bus.b          = r_b;
  assign io_bus.busy       = (r_state == S_APPLY) || (r_state == S_SETTLE);
  assign io_bus.done       = (r_state == S_FINISH);
  assign io_bus.pass       = r_pass;
  assign io_bus.err_cnt    = r_err_cnt;
  assign io_bus.fail_vec   = r_fail_vec;
  assign io_bus.fail_valid = r_fail_valid;

endmodule

// File: tb/tb_quad_gate_bist_ctrl.sv
// Bench for quad_gate_bist_ctrl: directed runs push expected DONE results into a queue,
// a negedge monitor pops and compares when DONE is seen.
module tb_quad_gate_bist_ctrl;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   total;
  int   bad;
  int   y_mode;

  typedef struct {
    int         done_at;
    logic       pass;
    logic [8:0] err;
    logic [7:0] fvec;
    logic       fvld;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;

  quad_gate_bist_ctrl_if #(.WIDTH(4)) bus ();

  quad_gate_bist_ctrl #(.WIDTH(4), .SETTLE(2)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  // Gate package model: ideal 4-gate OR, optionally with output 2 stuck at 0.
  logic [3:0] stuck_mask;
  assign stuck_mask = (y_mode == 1) ? 4'b1011 : 4'b1111;
  assign bus.y = (bus.a | bus.b) & stuck_mask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL unexpected_done actual=1 required=0 at edge %0d", edge_cnt);
      end else begin
        cur = sbq.pop_front();
        chk("done_cycle", edge_cnt, cur.done_at);
        chk("pass", {31'd0, bus.pass}, {31'd0, cur.pass});
        chk("err_cnt", {23'd0, bus.err_cnt}, {23'd0, cur.err});
        chk("fail_vec", {24'd0, bus.fail_vec}, {24'd0, cur.fvec});
        chk("fail_valid", {31'd0, bus.fail_valid}, {31'd0, cur.fvld});
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("a_at_done", {28'd0, bus.a}, 32'd0);
        chk("b_at_done", {28'd0, bus.b}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a"}, {28'd0, bus.a}, 32'd0);
    chk({tag, "_b"}, {28'd0, bus.b}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, bus.pass}, 32'd0);
    chk({tag, "_err"}, {23'd0, bus.err_cnt}, 32'd0);
    chk({tag, "_fvec"}, {24'd0, bus.fail_vec}, 32'd0);
    chk({tag, "_fvld"}, {31'd0, bus.fail_valid}, 32'd0);
  endtask

  // Pulse START for one cycle; edge 0 is the next posedge, so cycle N is observed at edge_cnt == s+N.
  task automatic start_run(input logic [2:0] op, input int mode, input logic with_abort,
                           input int n_done, input logic p, input logic [8:0] e,
                           input logic [7:0] fv, input logic fvl, input logic push, output int s);
    exp_t x;
    @(negedge clk);
    y_mode     = mode;
    bus.op     = op;
    bus.start  = 1'b1;
    bus.abort  = with_abort;
    s          = edge_cnt;
    if (push) begin
      x.done_at = s + n_done;
      x.pass    = p;
      x.err     = e;
      x.fvec    = fv;
      x.fvld    = fvl;
      sbq.push_back(x);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 2000) begin
      @(negedge clk);
      k = k + 1;
    end
    if (sbq.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
      sbq.delete();
    end
  endtask

  task automatic wait_cycle(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  int s;

  initial begin
    total     = 0;
    bad       = 0;
    y_mode    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 3'b000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: OR against ideal OR model
    start_run(3'b000, 0, 1'b0, 769, 1'b1, 9'd0, 8'h00, 1'b0, 1'b1, s);
    wait_drain("t1");
    repeat (3) @(negedge clk);
    chk("t1_pass_held", {31'd0, bus.pass}, 32'd1);

    // 2: OR with Y[2] stuck at 0
    start_run(3'b000, 1, 1'b0, 769, 1'b0, 9'd192, 8'h04, 1'b1, 1'b1, s);
    wait_drain("t2");
    repeat (2) @(negedge clk);
    chk("t2_err_held", {23'd0, bus.err_cnt}, 32'd192);

    // 3: AND selected against the OR model
    start_run(3'b001, 0, 1'b0, 769, 1'b0, 9'd240, 8'h01, 1'b1, 1'b1, s);
    wait_drain("t3");
    repeat (2) @(negedge clk);

    // 4: re-START at cycle 50 ignored, ABORT at cycle 100
    start_run(3'b000, 0, 1'b0, 101, 1'b0, 9'd0, 8'h00, 1'b0, 1'b1, s);
    wait_cycle(s + 50);
    chk("t4_busy_mid", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.op    = 3'b001;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cycle(s + 100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_drain("t4");
    repeat (2) @(negedge clk);

    // 5: reset mid-run with a faulty device, then START+ABORT together from IDLE
    start_run(3'b000, 1, 1'b0, 0, 1'b0, 9'd0, 8'h00, 1'b0, 1'b0, s);
    wait_cycle(s + 50);
    chk("t5_fvld_before_rst", {31'd0, bus.fail_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    @(negedge clk);
    start_run(3'b000, 0, 1'b1, 769, 1'b1, 9'd0, 8'h00, 1'b0, 1'b1, s);
    wait_drain("t5");
    repeat (2) @(negedge clk);

    // 6: reserved OP finishes immediately
    start_run(3'b111, 0, 1'b0, 1, 1'b0, 9'd0, 8'h00, 1'b0, 1'b1, s);
    wait_drain("t6");
    repeat (2) @(negedge clk);
    chk("t6_idle_busy", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Reserved-OP run must never drive A/B.
  always @(negedge clk) begin
    if (!rst && bus.op === 3'b111 && sbq.size() != 0 && (bus.a !== 4'd0 || bus.b !== 4'd0)) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL t6_ab_zero actual=%0h%0h required=00", bus.a, bus.b);
    end
  end

endmodule
